// File: rtl/iommu_mem_rd_arb.sv
// iommu_mem_rd_arb: read-channel arbiter for the IOMMU implicit memory-access port.
// Shares one AXI-style AR/R channel pair between up to N_REQ internal walkers
// (0=DDT walker, 1=PDT walker, 2=PTW, 3=CQ fetch). Round-robin AR grant, one
// outstanding burst per requester, requester index used as the AXI ID, and R
// beats routed back combinationally by ID.
//
// Optional feature macro: IOMMU_MEM_ARB_PTW_PRIO_EN
//   defined   : requester 2 (PTW) wins whenever eligible; PTW grants leave the
//               round-robin pointer untouched.
//   undefined : pure round-robin across all requesters.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   req_valid_i/req_ready_o per-requester AR request / one-hot grant
//   req_addr_i, req_len_i   packed per-requester address and burst length
//   rsp_valid_o/rsp_ready_i per-requester R beat handshake
//   rsp_data_o/last_o/err_o shared R payload (err = r_resp_i[1])
//   ar_*                    AXI AR channel toward the master mux
//   r_*                     AXI R channel from the master mux
//   busy_o                  per-requester outstanding-burst flag
//   stray_o                 one-cycle pulse after an unroutable R beat is dropped
module iommu_mem_rd_arb #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ID_WIDTH   = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,

    input  logic [N_REQ-1:0]            req_valid_i,
    output logic [N_REQ-1:0]            req_ready_o,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [N_REQ*8-1:0]          req_len_i,

    output logic [N_REQ-1:0]            rsp_valid_o,
    input  logic [N_REQ-1:0]            rsp_ready_i,
    output logic [DATA_WIDTH-1:0]       rsp_data_o,
    output logic                        rsp_last_o,
    output logic                        rsp_err_o,

    output logic                        ar_valid_o,
    input  logic                        ar_ready_i,
    output logic [ADDR_WIDTH-1:0]       ar_addr_o,
    output logic [7:0]                  ar_len_o,
    output logic [ID_WIDTH-1:0]         ar_id_o,

    input  logic                        r_valid_i,
    output logic                        r_ready_o,
    input  logic [DATA_WIDTH-1:0]       r_data_i,
    input  logic [ID_WIDTH-1:0]         r_id_i,
    input  logic [1:0]                  r_resp_i,
    input  logic                        r_last_i,

    output logic [N_REQ-1:0]            busy_o,
    output logic                        stray_o
);

    localparam int unsigned PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned LEN_W   = 8;
    localparam int unsigned PTW_IDX = 2;

    // Elaboration-time parameter sanity.
    generate
        if (ID_WIDTH < $clog2(N_REQ)) begin : g_id_width_chk
            $error("iommu_mem_rd_arb: ID_WIDTH too small to carry the requester index");
        end
        if (N_REQ < 2 || N_REQ > 8) begin : g_n_req_chk
            $error("iommu_mem_rd_arb: N_REQ must be within 2..8");
        end
    endgenerate

    // State
    logic                  ar_valid_q;
    logic [ADDR_WIDTH-1:0] ar_addr_q;
    logic [LEN_W-1:0]      ar_len_q;
    logic [ID_WIDTH-1:0]   ar_id_q;
    logic [N_REQ-1:0]      busy_q;
    logic [PTR_W-1:0]      ptr_q;
    logic                  stray_q;

    // Combinational
    logic [N_REQ-1:0]      eligible;
    logic                  slot_free;
    logic                  rr_any;
    logic [PTR_W-1:0]      rr_idx;
    int unsigned           rr_cand;
    logic                  grant_any;
    logic                  grant_rr;
    logic [PTR_W-1:0]      grant_idx;
    logic [ADDR_WIDTH-1:0] grant_addr;
    logic [LEN_W-1:0]      grant_len;
    logic [PTR_W-1:0]      ptr_d;
    logic                  hit;
    logic                  hit_rdy;
    logic                  r_hs;
    logic [N_REQ-1:0]      busy_d;
    logic                  resp_unused;

    assign resp_unused = r_resp_i[0];

    // AR grant: optional PTW priority, otherwise first eligible at/after ptr.
    always_comb begin
        eligible   = req_valid_i & ~busy_q;
        slot_free  = ~ar_valid_q | ar_ready_i;
        rr_any     = 1'b0;
        rr_idx     = '0;
        rr_cand    = 0;
        grant_any  = 1'b0;
        grant_rr   = 1'b0;
        grant_idx  = '0;
        grant_addr = '0;
        grant_len  = '0;
        ptr_d      = ptr_q;
        req_ready_o = '0;

        for (int unsigned i = 0; i < N_REQ; i++) begin
            rr_cand = (32'(ptr_q) + i) % N_REQ;
            if (!rr_any && eligible[rr_cand]) begin
                rr_any = 1'b1;
                rr_idx = PTR_W'(rr_cand);
            end
        end

        if (slot_free && !rst_i) begin
`ifdef IOMMU_MEM_ARB_PTW_PRIO_EN
            if (N_REQ > PTW_IDX && eligible[PTW_IDX % N_REQ]) begin
                grant_any = 1'b1;
                grant_idx = PTR_W'(PTW_IDX % N_REQ);
            end else if (rr_any) begin
                grant_any = 1'b1;
                grant_rr  = 1'b1;
                grant_idx = rr_idx;
            end
`else
            if (rr_any) begin
                grant_any = 1'b1;
                grant_rr  = 1'b1;
                grant_idx = rr_idx;
            end
`endif
        end

        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (grant_any && grant_idx == PTR_W'(k)) begin
                req_ready_o[k] = 1'b1;
                grant_addr     = req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                grant_len      = req_len_i[k*LEN_W +: LEN_W];
            end
        end

        if (grant_rr) begin
            ptr_d = PTR_W'((32'(grant_idx) + 32'd1) % N_REQ);
        end
    end

    // R routing by ID; unknown or idle IDs are accepted and dropped.
    always_comb begin
        hit         = 1'b0;
        hit_rdy     = 1'b0;
        rsp_valid_o = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (busy_q[k] && r_id_i == ID_WIDTH'(k)) begin
                hit            = 1'b1;
                hit_rdy        = rsp_ready_i[k];
                rsp_valid_o[k] = r_valid_i & ~rst_i;
            end
        end
        r_ready_o  = rst_i ? 1'b0 : (hit ? hit_rdy : 1'b1);
        r_hs       = r_valid_i & r_ready_o;
        rsp_data_o = rst_i ? '0 : r_data_i;
        rsp_last_o = r_last_i & ~rst_i;
        rsp_err_o  = r_resp_i[1] & ~rst_i;
    end

    // Outstanding flags: set on grant, cleared on the accepted last beat.
    always_comb begin
        busy_d = busy_q;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (r_hs && r_last_i && busy_q[k] && r_id_i == ID_WIDTH'(k)) begin
                busy_d[k] = 1'b0;
            end
            if (grant_any && grant_idx == PTR_W'(k)) begin
                busy_d[k] = 1'b1;
            end
        end
    end

    // AR registers, pointer, busy and stray pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ar_valid_q <= 1'b0;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_id_q    <= '0;
            busy_q     <= '0;
            ptr_q      <= '0;
            stray_q    <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            stray_q <= r_hs & ~hit;
            ptr_q   <= ptr_d;
            if (slot_free) begin
                ar_valid_q <= grant_any;
                if (grant_any) begin
                    ar_addr_q <= grant_addr;
                    ar_len_q  <= grant_len;
                    ar_id_q   <= ID_WIDTH'(grant_idx);
                end
            end
        end
    end

    assign ar_valid_o = ar_valid_q;
    assign ar_addr_o  = ar_addr_q;
    assign ar_len_o   = ar_len_q;
    assign ar_id_o    = ar_id_q;
    assign busy_o     = busy_q;
    assign stray_o    = stray_q;

endmodule

// File: tb/tb_iommu_mem_rd_arb.sv
`timescale 1ns/1ps
module tb_iommu_mem_rd_arb;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned AW    = 64;
    localparam int unsigned DW    = 64;
    localparam int unsigned IW    = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ-1:0]      req_ready;
    logic [N_REQ*AW-1:0]   req_addr;
    logic [N_REQ*8-1:0]    req_len;
    logic [N_REQ-1:0]      rsp_valid;
    logic [N_REQ-1:0]      rsp_ready;
    logic [DW-1:0]         rsp_data;
    logic                  rsp_last;
    logic                  rsp_err;
    logic                  ar_valid;
    logic                  ar_ready;
    logic [AW-1:0]         ar_addr;
    logic [7:0]            ar_len;
    logic [IW-1:0]         ar_id;
    logic                  r_valid;
    logic                  r_ready;
    logic [DW-1:0]         r_data;
    logic [IW-1:0]         r_id;
    logic [1:0]            r_resp;
    logic                  r_last;
    logic [N_REQ-1:0]      busy;
    logic                  stray;

    iommu_mem_rd_arb #(
        .N_REQ(N_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_addr_i(req_addr), .req_len_i(req_len),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_data_o(rsp_data), .rsp_last_o(rsp_last), .rsp_err_o(rsp_err),
        .ar_valid_o(ar_valid), .ar_ready_i(ar_ready), .ar_addr_o(ar_addr),
        .ar_len_o(ar_len), .ar_id_o(ar_id),
        .r_valid_i(r_valid), .r_ready_o(r_ready), .r_data_i(r_data),
        .r_id_i(r_id), .r_resp_i(r_resp), .r_last_i(r_last),
        .busy_o(busy), .stray_o(stray)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [AW-1:0] addr;
        logic [7:0]    len;
    } ar_exp_t;

    typedef struct packed {
        logic [2:0]    k;
        logic [DW-1:0] data;
        logic          last;
        logic          err;
    } r_exp_t;

    ar_exp_t          ar_q[$];
    r_exp_t           r_q[$];
    ar_exp_t          ar_e;
    r_exp_t           r_e;
    int               exp_stray = 0;
    int               checks    = 0;
    int               failures  = 0;
    logic [N_REQ-1:0] last_grant = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Advance one cycle; requesters drop valid once granted.
    task automatic tick();
        @(posedge clk);
        #1;
        req_valid = req_valid & ~last_grant;
    endtask

    task automatic push_ar(input int k, input logic [AW-1:0] a, input logic [7:0] l);
        ar_exp_t e;
        e.id = IW'(k); e.addr = a; e.len = l;
        ar_q.push_back(e);
    endtask

    task automatic push_r(input int k, input logic [DW-1:0] d, input logic l, input logic er);
        r_exp_t e;
        e.k = 3'(k); e.data = d; e.last = l; e.err = er;
        r_q.push_back(e);
    endtask

    task automatic drive_r(input int id, input logic [DW-1:0] d, input logic l, input logic [1:0] rs);
        r_valid = 1'b1; r_id = IW'(id); r_data = d; r_last = l; r_resp = rs;
    endtask

    // Monitor: pops scoreboard entries on every observed handshake / pulse.
    always @(negedge clk) begin
        if (rst) begin
            last_grant = '0;
        end else begin
            last_grant = req_ready;
            if (ar_valid && ar_ready) begin
                if (ar_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL ar_unexpected actual_id=%0d required=none", ar_id);
                end else begin
                    ar_e = ar_q.pop_front();
                    check("ar_id", 64'(ar_id), 64'(ar_e.id));
                    check("ar_addr", ar_addr, ar_e.addr);
                    check("ar_len", 64'(ar_len), 64'(ar_e.len));
                end
            end
            for (int k = 0; k < N_REQ; k++) begin
                if (rsp_valid[k] && rsp_ready[k]) begin
                    if (r_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL r_unexpected actual_k=%0d required=none", k);
                    end else begin
                        r_e = r_q.pop_front();
                        check("r_owner", 64'(k), 64'(r_e.k));
                        check("r_data", rsp_data, r_e.data);
                        check("r_last", 64'(rsp_last), 64'(r_e.last));
                        check("r_err", 64'(rsp_err), 64'(r_e.err));
                    end
                end
            end
            if (stray) begin
                check("stray_expected", 64'(exp_stray > 0), 64'd1);
                if (exp_stray > 0) exp_stray--;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int beat;
        int cyc;
        logic [AW-1:0] a0;

        rst = 1'b1;
        req_valid = '0; req_addr = '0; req_len = '0;
        rsp_ready = '1; ar_ready = 1'b1;
        r_valid = 1'b0; r_id = IW'(5); r_data = '0; r_resp = 2'b00; r_last = 1'b0;

        // Reset state, with all requesters already asking
        for (int k = 0; k < N_REQ; k++) req_addr[k*AW +: AW] = 64'h1000_0000 + 64'(k) * 64'h100;
        req_valid = 4'hF;
        tick(); tick();
        check("rst_ar_valid", 64'(ar_valid), 64'd0);
        check("rst_ar_addr", ar_addr, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_stray", 64'(stray), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_r_ready", 64'(r_ready), 64'd0);

        // Test 1: all four at once, one AR per cycle
`ifdef IOMMU_MEM_ARB_PTW_PRIO_EN
        push_ar(2, 64'h1000_0200, 8'd0);
        push_ar(0, 64'h1000_0000, 8'd0);
        push_ar(1, 64'h1000_0100, 8'd0);
        push_ar(3, 64'h1000_0300, 8'd0);
`else
        for (int k = 0; k < N_REQ; k++) push_ar(k, 64'h1000_0000 + 64'(k) * 64'h100, 8'd0);
`endif
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("t1_ar_idle", 64'(ar_valid), 64'd0);
        check("t1_busy_all", 64'(busy), 64'hF);
        for (int k = 0; k < N_REQ; k++) begin
            drive_r(k, 64'hC0 + 64'(k), 1'b1, 2'b00);
            push_r(k, 64'hC0 + 64'(k), 1'b1, 1'b0);
            tick();
        end
        r_valid = 1'b0;
        #1 check("t1_busy_clear", 64'(busy), 64'd0);

        // Test 2: 4-beat burst with rsp_ready toggling, error on beat 2
        req_addr[1*AW +: AW] = 64'h8000_1000;
        req_len[1*8 +: 8] = 8'd3;
        req_valid = 4'b0010;
        push_ar(1, 64'h8000_1000, 8'd3);
        tick(); tick();
        beat = 0; cyc = 0;
        while (beat < 4 && cyc < 20) begin
            drive_r(1, 64'hD0 + 64'(beat), beat == 3, (beat == 2) ? 2'b10 : 2'b00);
            rsp_ready = ((cyc % 2) == 0) ? 4'b0010 : 4'b0000;
            #1 check("t2_r_ready_mirror", 64'(r_ready), 64'(rsp_ready[1]));
            if (rsp_ready[1]) push_r(1, 64'hD0 + 64'(beat), beat == 3, beat == 2);
            tick();
            if (rsp_ready[1]) beat++;
            cyc++;
        end
        r_valid = 1'b0; rsp_ready = '1;
        #1 check("t2_busy_clear", 64'(busy), 64'd0);

        // Test 3: AR stall holds registers, then req 3 granted on handshake cycle
        a0 = 64'h0000_0000_4000_0040;
        req_addr[0 +: AW] = a0;
        req_len[0 +: 8] = 8'd5;
        ar_ready = 1'b0;
        req_valid = 4'b0001;
        push_ar(0, a0, 8'd5);
        tick();
        req_addr[3*AW +: AW] = 64'h7000_0300;
        req_len[3*8 +: 8] = 8'd0;
        req_valid = req_valid | 4'b1000;
        push_ar(3, 64'h7000_0300, 8'd0);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t3_stall_addr", ar_addr, a0);
            check("t3_stall_len_id", {ar_len, 48'd0, 4'(ar_id), 3'd0, ar_valid}, {8'd5, 48'd0, 4'd0, 3'd0, 1'b1});
            check("t3_stall_no_grant", 64'(req_ready), 64'd0);
            tick();
        end
        ar_ready = 1'b1;
        #1 check("t3_grant_req3", 64'(req_ready), 64'b1000);
        tick();
        check("t3_ar_id3", {60'd0, ar_id}, 64'd3);
        tick();

        // Test 4: busy requester 0 re-requests; re-granted after its last beat
        req_valid = 4'b0001;
        for (int b = 0; b < 6; b++) begin
            drive_r(0, 64'hE0 + 64'(b), b == 5, 2'b00);
            push_r(0, 64'hE0 + 64'(b), b == 5, 1'b0);
            #1 check("t4_no_regrant", 64'(req_ready), 64'd0);
            tick();
        end
        req_len[0 +: 8] = 8'd0;
        push_ar(0, a0, 8'd0);
        drive_r(3, 64'hF3, 1'b1, 2'b00);
        push_r(3, 64'hF3, 1'b1, 1'b0);
        #1 check("t4_regrant", 64'(req_ready), 64'b0001);
        tick();
        r_valid = 1'b0;
        #1 check("t4_grant_and_complete", 64'(busy), 64'b0001);
        tick();
        drive_r(0, 64'hE6, 1'b1, 2'b00);
        push_r(0, 64'hE6, 1'b1, 1'b0);
        tick();
        r_valid = 1'b0;
        #1 check("t4_busy_clear", 64'(busy), 64'd0);

        // Test 5: stray beats (out-of-range id, idle id)
        for (int s = 0; s < 2; s++) begin
            drive_r((s == 0) ? 5 : 2, 64'hBAD, s == 1, 2'b00);
            rsp_ready = '0;
            exp_stray++;
            #1;
            check("t5_stray_r_ready", 64'(r_ready), 64'd1);
            check("t5_stray_no_rsp", 64'(rsp_valid), 64'd0);
            tick();
            r_valid = 1'b0; rsp_ready = '1;
            #1 check("t5_stray_pulse", 64'(stray), 64'd1);
            tick();
            check("t5_stray_drop", 64'(stray), 64'd0);
        end

        // Test 6: reset mid-burst; leftover beats become strays
        req_addr[2*AW +: AW] = 64'h9000_2000;
        req_len[2*8 +: 8] = 8'd3;
        req_valid = 4'b0100;
        push_ar(2, 64'h9000_2000, 8'd3);
        tick(); tick();
        drive_r(2, 64'hB0, 1'b0, 2'b00);
        push_r(2, 64'hB0, 1'b0, 1'b0);
        req_valid = 4'b0010;
        ar_ready = 1'b0;
        tick();
        r_valid = 1'b0;
        #1 check("t6_pre_busy", 64'(busy), 64'b0110);
        rst = 1'b1;
        #1;
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_ar_valid", 64'(ar_valid), 64'd0);
        tick();
        rst = 1'b0;
        ar_ready = 1'b1;
        req_valid = '0;
        for (int b = 1; b < 4; b++) begin
            drive_r(2, 64'hB0 + 64'(b), b == 3, 2'b00);
            exp_stray++;
            tick();
        end
        r_valid = 1'b0;
        tick(); tick();

        check("end_ar_queue_empty", 64'(ar_q.size()), 64'd0);
        check("end_r_queue_empty", 64'(r_q.size()), 64'd0);
        check("end_stray_accounted", 64'(exp_stray), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
